// File: rtl/VX_gpu_pkg.sv
// Shared fetch-stage types and sizing helpers for the GPU core.
package VX_gpu_pkg;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FETCH_NUM_WARPS       = 4;
  localparam int FETCH_MAX_OUTSTANDING = 2;
  localparam int FETCH_UUID_WIDTH      = 1;
  localparam int FETCH_NW_WIDTH        = clog2_min1(FETCH_NUM_WARPS);
  localparam int FETCH_SLOT_BITS       = clog2_min1(FETCH_MAX_OUTSTANDING);
  localparam int FETCH_TAG_WIDTH       = FETCH_UUID_WIDTH + FETCH_NW_WIDTH + FETCH_SLOT_BITS;

  typedef struct packed {
    logic [FETCH_UUID_WIDTH-1:0] uuid;
    logic [FETCH_NW_WIDTH-1:0]   wid;
    logic [FETCH_SLOT_BITS-1:0]  slot;
  } fetch_tag_t;

endpackage

// File: rtl/VX_dp_ram.sv
// Dual-port RAM: synchronous write, asynchronous read (LUTRAM style).
module VX_dp_ram #(
  parameter int DATAW = 1,
  parameter int SIZE  = 2,
  parameter int ADDRW = 1
) (
  input  logic             clk,
  input  logic             write,
  input  logic [ADDRW-1:0] waddr,
  input  logic [DATAW-1:0] wdata,
  input  logic [ADDRW-1:0] raddr,
  output logic [DATAW-1:0] rdata
);

  logic [DATAW-1:0] mem_r [SIZE];

  // Storage only, no reset.
  always_ff @(posedge clk) begin
    if (write) mem_r[waddr] <= wdata;
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/vx_fetch_multi_chk.sv
// Protocol checker for the multi-outstanding fetch stage.
module vx_fetch_multi_chk #(
  parameter int NUM_WARPS = 4
) (
  input logic                 clk,
  input logic                 reset,
  input logic [NUM_WARPS-1:0] credit_underflow,
  input logic                 bad_rsp
);

  a_credit_underflow: assert property (@(posedge clk) disable iff (reset) !(|credit_underflow));
  a_rsp_slot_valid:   assert property (@(posedge clk) disable iff (reset) !bad_rsp);

endmodule

// File: rtl/vx_fetch_warp_tracker.sv
// Per-warp slot/stale bitmaps, lowest-free slot encoder and ibuffer credit counter.
module vx_fetch_warp_tracker #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int IBUF_SIZE       = 4,
  parameter int SLOT_BITS       = 1,
  parameter int CREDIT_BITS     = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc,
  input  logic                       flush,
  input  logic                       rsp_fire,
  input  logic                       rsp_drop,
  input  logic [SLOT_BITS-1:0]       rsp_slot,
  input  logic                       ibuf_pop,
  output logic                       can_issue,
  output logic [SLOT_BITS-1:0]       alloc_slot,
  output logic [MAX_OUTSTANDING-1:0] is_stale,
  output logic [MAX_OUTSTANDING-1:0] slot_valid,
  output logic                       underflow
);

  logic [MAX_OUTSTANDING-1:0] valid_r, stale_r, valid_nxt_s, stale_nxt_s;
  logic [MAX_OUTSTANDING-1:0] rsp_mask_s, alloc_mask_s, free_s;
  logic [CREDIT_BITS-1:0]     credit_r, credit_nxt_s;
  logic [CREDIT_BITS:0]       credit_sum_s, credit_dec_s;
  logic                       has_free_s;

  // A slot retiring this cycle is already free for a new allocation.
  always_comb begin
    rsp_mask_s = {MAX_OUTSTANDING{1'b0}};
    alloc_slot = {SLOT_BITS{1'b0}};
    has_free_s = 1'b0;
    for (int s = 0; s < MAX_OUTSTANDING; s++) begin
      rsp_mask_s[s] = rsp_fire && (rsp_slot == SLOT_BITS'(s));
    end
    free_s = ~valid_r | rsp_mask_s;
    for (int s = 0; s < MAX_OUTSTANDING; s++) begin
      alloc_slot = (free_s[s] && !has_free_s) ? SLOT_BITS'(s) : alloc_slot;
      has_free_s = has_free_s | free_s[s];
    end
    alloc_mask_s = {MAX_OUTSTANDING{1'b0}};
    for (int s = 0; s < MAX_OUTSTANDING; s++) begin
      alloc_mask_s[s] = alloc && (alloc_slot == SLOT_BITS'(s));
    end
  end

  assign can_issue = has_free_s && (credit_r < CREDIT_BITS'(IBUF_SIZE));

  // A flush marks every live slot stale, including one allocated in the same cycle.
  always_comb begin
    valid_nxt_s  = (valid_r & ~rsp_mask_s) | alloc_mask_s;
    stale_nxt_s  = ((stale_r | (flush ? valid_r : {MAX_OUTSTANDING{1'b0}})) & ~rsp_mask_s)
                 | (flush ? alloc_mask_s : {MAX_OUTSTANDING{1'b0}});
    credit_sum_s = {1'b0, credit_r} + {{CREDIT_BITS{1'b0}}, alloc};
    credit_dec_s = {{CREDIT_BITS{1'b0}}, ibuf_pop} + {{CREDIT_BITS{1'b0}}, rsp_fire && rsp_drop};
    underflow    = credit_sum_s < credit_dec_s;
    credit_nxt_s = underflow ? {CREDIT_BITS{1'b0}} : CREDIT_BITS'(credit_sum_s - credit_dec_s);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r  <= {MAX_OUTSTANDING{1'b0}};
      stale_r  <= {MAX_OUTSTANDING{1'b0}};
      credit_r <= {CREDIT_BITS{1'b0}};
    end else begin
      valid_r  <= valid_nxt_s;
      stale_r  <= stale_nxt_s;
      credit_r <= credit_nxt_s;
    end
  end

  assign is_stale   = stale_r;
  assign slot_valid = valid_r;

endmodule

// File: rtl/vx_fetch_multi.sv
// Instruction fetch with per-warp multiple outstanding icache requests, ibuffer
// credits and flush-driven response dropping.
module vx_fetch_multi import VX_gpu_pkg::*; #(
  parameter int NUM_WARPS       = 4,
  parameter int NUM_THREADS     = 4,
  parameter int PC_BITS         = 31,
  parameter int UUID_WIDTH      = 1,
  parameter int ADDR_WIDTH      = 30,
  parameter int WORD_SIZE       = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int IBUF_SIZE       = 4,
  localparam int NW_WIDTH  = clog2_min1(NUM_WARPS),
  localparam int SLOT_BITS = clog2_min1(MAX_OUTSTANDING),
  localparam int TAG_W     = UUID_WIDTH + NW_WIDTH + SLOT_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sched_valid,
  output logic                   sched_ready,
  input  logic [NW_WIDTH-1:0]    sched_wid,
  input  logic [PC_BITS-1:0]     sched_pc,
  input  logic [NUM_THREADS-1:0] sched_tmask,
  input  logic [UUID_WIDTH-1:0]  sched_uuid,
  input  logic                   flush_valid,
  input  logic [NW_WIDTH-1:0]    flush_wid,
  output logic                   icache_req_valid,
  input  logic                   icache_req_ready,
  output logic [ADDR_WIDTH-1:0]  icache_req_addr,
  output logic [TAG_W-1:0]       icache_req_tag,
  input  logic                   icache_rsp_valid,
  output logic                   icache_rsp_ready,
  input  logic [8*WORD_SIZE-1:0] icache_rsp_data,
  input  logic [TAG_W-1:0]       icache_rsp_tag,
  output logic                   fetch_valid,
  input  logic                   fetch_ready,
  output logic [NW_WIDTH-1:0]    fetch_wid,
  output logic [PC_BITS-1:0]     fetch_pc,
  output logic [NUM_THREADS-1:0] fetch_tmask,
  output logic [8*WORD_SIZE-1:0] fetch_instr,
  output logic [UUID_WIDTH-1:0]  fetch_uuid,
  input  logic [NUM_WARPS-1:0]   ibuf_pop,
  output logic                   busy
);

  localparam int SLOTS       = NUM_WARPS * MAX_OUTSTANDING;
  localparam int IDX_W       = clog2_min1(SLOTS);
  localparam int CREDIT_BITS = $clog2(IBUF_SIZE + 1);
  localparam int TDW         = PC_BITS + NUM_THREADS;
  localparam int RBW         = ADDR_WIDTH + TAG_W;

  logic [NUM_WARPS-1:0]       can_issue_s, underflow_s;
  logic [SLOT_BITS-1:0]       alloc_slot_s [NUM_WARPS];
  logic [MAX_OUTSTANDING-1:0] stale_s [NUM_WARPS];
  logic [MAX_OUTSTANDING-1:0] valid_s [NUM_WARPS];
  logic [SLOT_BITS-1:0]       sched_slot_s, rsp_slot_s;
  logic [NW_WIDTH-1:0]        rsp_wid_s;
  logic [IDX_W-1:0]           waddr_s, raddr_s;
  logic [TDW-1:0]             rdata_s;
  logic                       sched_fire_s, rsp_fire_s, drop_s, rb_ready_s, rb_pop_s, slots_busy_s;
  logic [RBW-1:0]             rb_mem_r [2];
  logic                       rb_wr_r, rb_rd_r;
  logic [1:0]                 rb_cnt_r;

  assign sched_slot_s = alloc_slot_s[sched_wid];
  assign sched_ready  = rb_ready_s && can_issue_s[sched_wid];
  assign sched_fire_s = sched_valid && sched_ready;
  assign waddr_s      = IDX_W'(sched_wid) * IDX_W'(MAX_OUTSTANDING) + IDX_W'(sched_slot_s);

  // Response tag layout is {uuid, wid, slot}; a stale slot or same-cycle flush drops it.
  assign rsp_slot_s       = icache_rsp_tag[SLOT_BITS-1:0];
  assign rsp_wid_s        = icache_rsp_tag[SLOT_BITS +: NW_WIDTH];
  assign raddr_s          = IDX_W'(rsp_wid_s) * IDX_W'(MAX_OUTSTANDING) + IDX_W'(rsp_slot_s);
  assign drop_s           = stale_s[rsp_wid_s][rsp_slot_s] || (flush_valid && (flush_wid == rsp_wid_s));
  assign fetch_valid      = icache_rsp_valid && !drop_s;
  assign icache_rsp_ready = drop_s || fetch_ready;
  assign rsp_fire_s       = icache_rsp_valid && icache_rsp_ready;
  assign fetch_wid        = rsp_wid_s;
  assign fetch_uuid       = icache_rsp_tag[TAG_W-1 -: UUID_WIDTH];
  assign fetch_pc         = rdata_s[TDW-1 -: PC_BITS];
  assign fetch_tmask      = rdata_s[NUM_THREADS-1:0];
  assign fetch_instr      = icache_rsp_data;

  VX_dp_ram #(.DATAW(TDW), .SIZE(SLOTS), .ADDRW(IDX_W)) u_tag_store (
    .clk   (clk),
    .write (sched_fire_s),
    .waddr (waddr_s),
    .wdata ({sched_pc, sched_tmask}),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    vx_fetch_warp_tracker #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .IBUF_SIZE       (IBUF_SIZE),
      .SLOT_BITS       (SLOT_BITS),
      .CREDIT_BITS     (CREDIT_BITS)
    ) u_tracker (
      .clk        (clk),
      .reset      (reset),
      .alloc      (sched_fire_s && (sched_wid == NW_WIDTH'(w))),
      .flush      (flush_valid && (flush_wid == NW_WIDTH'(w))),
      .rsp_fire   (rsp_fire_s && (rsp_wid_s == NW_WIDTH'(w))),
      .rsp_drop   (drop_s),
      .rsp_slot   (rsp_slot_s),
      .ibuf_pop   (ibuf_pop[w]),
      .can_issue  (can_issue_s[w]),
      .alloc_slot (alloc_slot_s[w]),
      .is_stale   (stale_s[w]),
      .slot_valid (valid_s[w]),
      .underflow  (underflow_s[w])
    );
  end

  // Two-entry elastic request buffer; read-only, full-word requests.
  assign rb_ready_s       = (rb_cnt_r != 2'd2);
  assign rb_pop_s         = icache_req_valid && icache_req_ready;
  assign icache_req_valid = (rb_cnt_r != 2'd0);
  assign {icache_req_addr, icache_req_tag} = rb_mem_r[rb_rd_r];

  always_ff @(posedge clk) begin
    if (reset) begin
      rb_wr_r  <= 1'b0;
      rb_rd_r  <= 1'b0;
      rb_cnt_r <= 2'd0;
    end else begin
      if (sched_fire_s) rb_wr_r <= ~rb_wr_r;
      if (rb_pop_s)     rb_rd_r <= ~rb_rd_r;
      rb_cnt_r <= rb_cnt_r + {1'b0, sched_fire_s} - {1'b0, rb_pop_s};
    end
  end

  always_ff @(posedge clk) begin
    if (sched_fire_s) rb_mem_r[rb_wr_r] <= {sched_pc[1 +: ADDR_WIDTH], sched_uuid, sched_wid, sched_slot_s};
  end

  always_comb begin
    slots_busy_s = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) slots_busy_s = slots_busy_s | (|valid_s[w]);
  end

  assign busy = slots_busy_s || (rb_cnt_r != 2'd0);

  vx_fetch_multi_chk #(.NUM_WARPS(NUM_WARPS)) u_chk (
    .clk              (clk),
    .reset            (reset),
    .credit_underflow (underflow_s),
    .bad_rsp          (icache_rsp_valid && !valid_s[rsp_wid_s][rsp_slot_s])
  );

endmodule

// File: tb/tb_vx_fetch_multi.sv
// Scoreboard bench for vx_fetch_multi: the bench plays scheduler, icache and ibuffer.
module tb_vx_fetch_multi;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sched_valid = 1'b0, sched_ready;
  logic [1:0]  sched_wid = 2'd0;
  logic [30:0] sched_pc = 31'd0;
  logic [3:0]  sched_tmask = 4'd0;
  logic        sched_uuid = 1'b0;
  logic        flush_valid = 1'b0;
  logic [1:0]  flush_wid = 2'd0;
  logic        icache_req_valid, icache_req_ready = 1'b1;
  logic [29:0] icache_req_addr;
  logic [3:0]  icache_req_tag;
  logic        icache_rsp_valid = 1'b0, icache_rsp_ready;
  logic [31:0] icache_rsp_data = 32'd0;
  logic [3:0]  icache_rsp_tag = 4'd0;
  logic        fetch_valid, fetch_ready = 1'b1;
  logic [1:0]  fetch_wid;
  logic [30:0] fetch_pc;
  logic [3:0]  fetch_tmask;
  logic [31:0] fetch_instr;
  logic        fetch_uuid;
  logic [3:0]  ibuf_pop = 4'd0;
  logic        busy;

  typedef struct {
    logic [1:0]  wid;
    logic [30:0] pc;
    logic [3:0]  tmask;
    logic        uuid;
    logic [3:0]  tag;
    logic        stale;
  } ent_t;

  ent_t exp_req_q[$];
  ent_t pending[$];
  int   credit_m[4];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vx_fetch_multi dut (
    .clk(clk), .reset(reset),
    .sched_valid(sched_valid), .sched_ready(sched_ready), .sched_wid(sched_wid),
    .sched_pc(sched_pc), .sched_tmask(sched_tmask), .sched_uuid(sched_uuid),
    .flush_valid(flush_valid), .flush_wid(flush_wid),
    .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
    .icache_req_addr(icache_req_addr), .icache_req_tag(icache_req_tag),
    .icache_rsp_valid(icache_rsp_valid), .icache_rsp_ready(icache_rsp_ready),
    .icache_rsp_data(icache_rsp_data), .icache_rsp_tag(icache_rsp_tag),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_wid(fetch_wid),
    .fetch_pc(fetch_pc), .fetch_tmask(fetch_tmask), .fetch_instr(fetch_instr),
    .fetch_uuid(fetch_uuid), .ibuf_pop(ibuf_pop), .busy(busy)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  // Icache request side: requests must leave in scheduler order with matching fields.
  always @(posedge clk) begin
    ent_t e;
    if (!reset && icache_req_valid && icache_req_ready) begin
      checks++;
      if (exp_req_q.size() == 0) begin
        errors++;
        $display("FAIL req_unexpected: got addr=%h tag=%h, required no request", icache_req_addr, icache_req_tag);
      end else begin
        e = exp_req_q.pop_front();
        if (icache_req_addr !== e.pc[30:1] || icache_req_tag[3] !== e.uuid || icache_req_tag[2:1] !== e.wid) begin
          errors++;
          $display("FAIL req_fields: got addr=%h uuid=%b wid=%0d, required addr=%h uuid=%b wid=%0d",
                   icache_req_addr, icache_req_tag[3], icache_req_tag[2:1], e.pc[30:1], e.uuid, e.wid);
        end
        e.tag = icache_req_tag;
        pending.push_back(e);
      end
    end
  end

  task automatic push_exp(input logic [1:0] w, input logic [30:0] pc, input logic [3:0] tm,
                          input logic u, input logic st);
    ent_t e;
    e.wid = w; e.pc = pc; e.tmask = tm; e.uuid = u; e.tag = 4'h0; e.stale = st;
    exp_req_q.push_back(e);
    credit_m[w]++;
  endtask

  task automatic mark_flush(input logic [1:0] w);
    foreach (pending[i])   if (pending[i].wid == w)   pending[i].stale = 1'b1;
    foreach (exp_req_q[i]) if (exp_req_q[i].wid == w) exp_req_q[i].stale = 1'b1;
  endtask

  task automatic issue(input logic [1:0] w, input logic [30:0] pc, input logic [3:0] tm,
                       input logic u, input logic fl);
    int n = 0;
    @(negedge clk);
    sched_valid = 1'b1; sched_wid = w; sched_pc = pc; sched_tmask = tm; sched_uuid = u;
    flush_valid = fl; flush_wid = w;
    #1;
    while (sched_ready !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (sched_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_stall: wid=%0d sched_ready=%b, required 1 within 20 cycles", w, sched_ready);
    end else begin
      if (fl) mark_flush(w);
      push_exp(w, pc, tm, u, fl);
    end
    @(negedge clk);
    sched_valid = 1'b0; flush_valid = 1'b0;
  endtask

  task automatic flush(input logic [1:0] w);
    @(negedge clk);
    flush_valid = 1'b1; flush_wid = w;
    mark_flush(w);
    @(negedge clk);
    flush_valid = 1'b0;
  endtask

  task automatic wait_pending(input int n);
    int c = 0;
    while (pending.size() < n && c < 20) begin
      @(negedge clk); c++;
    end
    checks++;
    if (pending.size() < n) begin
      errors++;
      $display("FAIL wait_req: got %0d requests, required %0d", pending.size(), n);
    end
  endtask

  task automatic respond(input int idx, input logic [31:0] data, input int stall);
    ent_t e;
    int   n;
    if (idx >= pending.size()) begin
      checks++; errors++;
      $display("FAIL respond_idx: got index %0d, required below %0d", idx, pending.size());
      return;
    end
    e = pending[idx];
    pending.delete(idx);
    n = e.stale ? 0 : stall;
    @(negedge clk);
    icache_rsp_valid = 1'b1; icache_rsp_tag = e.tag; icache_rsp_data = data;
    for (int c = 0; c <= n; c++) begin
      fetch_ready = (c == n);
      #1;
      checks++;
      if (e.stale) begin
        if (fetch_valid !== 1'b0 || icache_rsp_ready !== 1'b1) begin
          errors++;
          $display("FAIL drop: got fetch_valid=%b rsp_ready=%b, required 0 1 (wid=%0d pc=%h)",
                   fetch_valid, icache_rsp_ready, e.wid, e.pc);
        end
      end else if (fetch_valid !== 1'b1 || fetch_wid !== e.wid || fetch_pc !== e.pc ||
                   fetch_tmask !== e.tmask || fetch_uuid !== e.uuid || fetch_instr !== data ||
                   icache_rsp_ready !== fetch_ready) begin
        errors++;
        $display("FAIL fetch: got v=%b wid=%0d pc=%h tm=%h uuid=%b instr=%h rdy=%b, required v=1 wid=%0d pc=%h tm=%h uuid=%b instr=%h rdy=%b",
                 fetch_valid, fetch_wid, fetch_pc, fetch_tmask, fetch_uuid, fetch_instr, icache_rsp_ready,
                 e.wid, e.pc, e.tmask, e.uuid, data, fetch_ready);
      end
      @(negedge clk);
    end
    icache_rsp_valid = 1'b0; fetch_ready = 1'b1;
    if (e.stale) credit_m[e.wid]--;
  endtask

  task automatic drain();
    int n = 0;
    while ((credit_m[0] + credit_m[1] + credit_m[2] + credit_m[3]) != 0 && n < 16) begin
      @(negedge clk);
      for (int w = 0; w < 4; w++) begin
        ibuf_pop[w] = (credit_m[w] > 0);
        if (credit_m[w] > 0) credit_m[w]--;
      end
      n++;
    end
    @(negedge clk);
    ibuf_pop = 4'd0;
  endtask

  task automatic check_idle(input string name);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got busy=%b, required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (icache_req_valid !== 1'b0 || busy !== 1'b0 || fetch_valid !== 1'b0 || sched_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: got req_valid=%b busy=%b fetch_valid=%b sched_ready=%b, required 0 0 0 1",
               icache_req_valid, busy, fetch_valid, sched_ready);
    end
  endtask

  task automatic test_basic();
    issue(2'd0, 31'h40, 4'hF, 1'b1, 1'b0);
    #1;
    checks++;
    if (icache_req_valid !== 1'b1 || icache_req_addr !== 30'h20) begin
      errors++;
      $display("FAIL basic_req: got valid=%b addr=%h, required 1 00000020", icache_req_valid, icache_req_addr);
    end
    wait_pending(1);
    repeat (2) @(negedge clk);
    respond(0, 32'h0000_0013, 0);
    check_idle("basic_idle");
    drain();
  endtask

  task automatic test_outstanding();
    ent_t e;
    issue(2'd1, 31'h100, 4'h3, 1'b0, 1'b0);
    issue(2'd1, 31'h104, 4'h3, 1'b1, 1'b0);
    wait_pending(2);
    @(negedge clk);
    sched_valid = 1'b1; sched_wid = 2'd1; sched_pc = 31'h108; sched_tmask = 4'h5; sched_uuid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (sched_ready !== 1'b0) begin
        errors++;
        $display("FAIL outstanding_block: got sched_ready=%b, required 0", sched_ready);
      end
      @(negedge clk);
    end
    e = pending.pop_front();
    icache_rsp_valid = 1'b1; icache_rsp_tag = e.tag; icache_rsp_data = 32'h1111_0100;
    #1;
    checks++;
    if (sched_ready !== 1'b1 || fetch_valid !== 1'b1 || fetch_pc !== e.pc) begin
      errors++;
      $display("FAIL outstanding_reenable: got sched_ready=%b fetch_valid=%b pc=%h, required 1 1 %h",
               sched_ready, fetch_valid, fetch_pc, e.pc);
    end else begin
      push_exp(2'd1, 31'h108, 4'h5, 1'b0, 1'b0);
    end
    @(negedge clk);
    icache_rsp_valid = 1'b0; sched_valid = 1'b0;
    wait_pending(2);
    respond(0, 32'h1111_0104, 0);
    respond(0, 32'h1111_0108, 0);
    check_idle("outstanding_idle");
    drain();
  endtask

  task automatic test_credit();
    for (int b = 0; b < 2; b++) begin
      issue(2'd2, 31'h200 + 31'(8 * b), 4'hA, 1'b0, 1'b0);
      issue(2'd2, 31'h204 + 31'(8 * b), 4'hA, 1'b1, 1'b0);
      wait_pending(2);
      respond(0, 32'h2222_0000 + 32'(b), 0);
      respond(0, 32'h2222_0010 + 32'(b), 0);
    end
    @(negedge clk);
    sched_valid = 1'b1; sched_wid = 2'd2; sched_pc = 31'h210; sched_tmask = 4'hC; sched_uuid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (sched_ready !== 1'b0) begin
        errors++;
        $display("FAIL credit_block: got sched_ready=%b, required 0 (cycle %0d)", sched_ready, c);
      end
      if (c == 2) begin
        ibuf_pop[2] = 1'b1;
        credit_m[2]--;
      end
      @(negedge clk);
    end
    ibuf_pop = 4'd0;
    #1;
    checks++;
    if (sched_ready !== 1'b1) begin
      errors++;
      $display("FAIL credit_release: got sched_ready=%b, required 1", sched_ready);
    end else begin
      push_exp(2'd2, 31'h210, 4'hC, 1'b1, 1'b0);
    end
    @(negedge clk);
    sched_valid = 1'b0;
    wait_pending(1);
    respond(0, 32'h2222_0210, 0);
    drain();
  endtask

  task automatic test_flush_drop();
    issue(2'd3, 31'h300, 4'h1, 1'b0, 1'b0);
    issue(2'd3, 31'h304, 4'h2, 1'b1, 1'b0);
    wait_pending(2);
    flush(2'd3);
    respond(1, 32'h3333_0304, 0);
    respond(0, 32'h3333_0300, 0);
    check_idle("flush_idle");
    issue(2'd3, 31'h380, 4'h4, 1'b1, 1'b0);
    wait_pending(1);
    respond(0, 32'h3333_0380, 0);
    drain();
  endtask

  task automatic test_same_cycle_flush();
    issue(2'd0, 31'h500, 4'h8, 1'b0, 1'b1);
    wait_pending(1);
    respond(0, 32'h5555_0500, 0);
    check_idle("same_flush_idle");
    drain();
  endtask

  task automatic test_back_to_back();
    issue(2'd0, 31'h600, 4'h1, 1'b0, 1'b0);
    issue(2'd1, 31'h610, 4'h2, 1'b1, 1'b0);
    issue(2'd2, 31'h620, 4'h4, 1'b0, 1'b0);
    issue(2'd3, 31'h630, 4'h8, 1'b1, 1'b0);
    issue(2'd0, 31'h640, 4'hF, 1'b1, 1'b0);
    wait_pending(5);
    respond(2, 32'hA000_0620, 5);
    for (int k = 0; k < 4; k++) respond(pending.size() - 1, 32'hA000_0700 + 32'(k), 5);
    check_idle("backpressure_idle");
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_outstanding();
    test_credit();
    test_flush_drop();
    test_same_cycle_flush();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_fetch_multi.md
# vx_fetch_multi

Parametrised instruction-fetch stage between the warp scheduler and the icache. It is the successor to the single-outstanding fetch unit. It allows up to `MAX_OUTSTANDING` in-flight icache requests per warp and always enforces per-warp ibuffer credits. A per-warp flush kills in-flight fetches of a redirected warp: their responses are dropped, and their slots and credits are returned.

## Interface
Parameters:
- `NUM_WARPS`, 4: number of warps; `NW_WIDTH` = max(1, clog2(NUM_WARPS)).
- `NUM_THREADS`, 4: thread-mask width.
- `PC_BITS`, 31: halfword-aligned PC width.
- `UUID_WIDTH`, 1: instruction UUID width.
- `ADDR_WIDTH`, 30: icache word-address width.
- `WORD_SIZE`, 4: icache word size in bytes.
- `MAX_OUTSTANDING`, 2: in-flight requests per warp (≥1); `SLOT_BITS` = max(1, clog2(MAX_OUTSTANDING)).
- `IBUF_SIZE`, 4: ibuffer depth per warp (≥ MAX_OUTSTANDING).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `sched_valid` / `sched_ready` in / out 1: scheduler handshake.
- `sched_wid` in NW_WIDTH: warp ID from the scheduler.
- `sched_pc` in PC_BITS: fetch PC.
- `sched_tmask` in NUM_THREADS: thread mask.
- `sched_uuid` in UUID_WIDTH: instruction UUID.
- `flush_valid` in 1, `flush_wid` in NW_WIDTH: kill all in-flight fetches of a warp.
- `icache_req_valid` / `icache_req_ready` out / in 1: icache request handshake.
- `icache_req_addr` out ADDR_WIDTH: icache word address.
- `icache_req_tag` out TAG_W: TAG_W = UUID_WIDTH + NW_WIDTH + SLOT_BITS; layout {uuid, wid, slot}.
- `icache_rsp_valid` / `icache_rsp_ready` in / out 1: icache response handshake.
- `icache_rsp_data` in 8·WORD_SIZE: instruction word.
- `icache_rsp_tag` in TAG_W: response tag.
- `fetch_valid` / `fetch_ready` out / in 1: handshake toward decode.
- `fetch_wid` out NW_WIDTH, `fetch_pc` out PC_BITS, `fetch_tmask` out NUM_THREADS, `fetch_instr` out 8·WORD_SIZE, `fetch_uuid` out UUID_WIDTH: decoded-bound fields.
- `ibuf_pop` in NUM_WARPS: one ibuffer entry freed per asserted bit.
- `busy` out 1: any slot occupied or request buffer non-empty.

## Operation
- Per-warp state:
  - `slot_valid[MAX_OUTSTANDING]`, `slot_stale[MAX_OUTSTANDING]`.
  - `credit` counter, clog2(IBUF_SIZE+1) bits. It counts in-flight plus ibuffer-resident entries.
- Accept rule: `sched_ready` = req_buf_ready && credit[wid] < IBUF_SIZE && any free slot for wid.
- On a scheduler fire:
  - Allocate the lowest-index free slot s.
  - Write {pc, tmask} into the tag store at {wid, s}.
  - Set `slot_valid`, and increment `credit`.
  - Push {pc[1 +: ADDR_WIDTH], {uuid, wid, s}} into the request buffer.
- Fixed request fields: byteen all-ones, read-only.
- On a response, decode {uuid, wid, s} and read the tag store asynchronously. The slot is then either live or dropped:
  - **Live** (slot not stale and no same-cycle flush of wid): `fetch_valid` = `icache_rsp_valid` and `icache_rsp_ready` = `fetch_ready`. Fields come from the tag store, and `fetch_instr` = rsp data. On fire, clear `slot_valid`. The credit is kept until `ibuf_pop`.
  - **Dropped**: `fetch_valid` = 0 and `icache_rsp_ready` = 1. On fire, clear `slot_valid` and `slot_stale`, and decrement `credit`.
- Flush of warp w sets `slot_stale` on every valid slot of w. A request firing in the same cycle for w is also marked stale.
- Credit update: incr = sched fire; decr = ibuf_pop[w] + stale drop. Both decrements may occur in one cycle (−2). Simultaneous incr and decr cancel. Underflow is an assertion failure.
- A response to a non-valid slot is an assertion failure.

## Timing
- Request buffer: 2-entry elastic, registered output. Scheduler fire at cycle N gives `icache_req_valid` at N+1 at the earliest.
- Response path is combinational, 0 cycles from `icache_rsp_valid` to `fetch_valid`.
- Full throughput: one request and one response per cycle.
- `sched_ready` may depend combinationally on `sched_wid`; it never depends on `sched_valid`.
- Reset values:
  - Slots invalid, stale clear, credits 0, request buffer empty.
  - `icache_req_valid` = 0, `busy` = 0.
  - `fetch_valid` follows `icache_rsp_valid`; upstream holds it at 0 in reset.
- Reset mid-operation discards all state. Responses arriving after reset are illegal.
- A stalled `fetch_ready` = 0 holds the response; a flush during the stall converts it to a drop in that cycle.

## Structure
- Shared package `VX_gpu_pkg`: `FETCH_SLOT_BITS`, `FETCH_TAG_WIDTH`, and `fetch_tag_t` packed struct {uuid, wid, slot}.
- Tag store: VX_dp_ram, LUTRAM, depth NUM_WARPS·MAX_OUTSTANDING, async read.
- Sub-module `vx_fetch_warp_tracker`, one instance per warp: slot bitmap, stale bitmap, lowest-free encoder, credit counter. Outputs `can_issue`, `alloc_slot`, `is_stale[s]`.

## Test plan
- **Basic fetch:** warp 0 fetches PC 0x40 (addr 0x20), icache returns after 3 cycles with 0x00000013 → `fetch_valid` with wid 0, pc 0x40, instr 0x13, uuid matching the request.
- **Outstanding limit:** MAX_OUTSTANDING=2, warp 1 issues 3 fetches with no response → third waits with `sched_ready`=0; first response re-enables it in the same cycle.
- **Credit limit:** IBUF_SIZE=4, no `ibuf_pop` → exactly 4 fetches for warp 2 are accepted, then stall; `ibuf_pop[2]`=1 for one cycle → one more is accepted.
- **Flush drop:** warp 3 has 2 in flight, flush wid 3 → both responses are dropped with `fetch_valid`=0, credit returns to 0, and a new PC issues and forwards normally.
- **Same-cycle flush:** flush and scheduler fire for the same warp in one cycle → that fetch's response is dropped.
- **Backpressure with out-of-order responses:** `fetch_ready`=0 for 5 cycles while responses return out of order across warps → data is held stable and each wid/pc pair is correct on release.
